// File: rtl/rx_frontend_mv.sv
// rx_frontend_mv: UART receive front end with 3-sample majority vote, 5..DATA_W_MAX data bits,
// parity/stop checking and a ready/valid output word. Optional feature macro: RX_BREAK_DETECT_EN.
module rx_frontend_mv #(
   parameter int CLK_DIV_W   = 16,
   parameter int DATA_W_MAX  = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CLK_DIV_W-1:0]  cr_clk_div_i,
   input  logic [3:0]            cr_ds_i,
   input  logic [1:0]            cr_p_i,
   input  logic                  cr_s_i,
   input  logic                  uart_rx_i,
   input  logic                  output_ready_i,
   output logic [DATA_W_MAX-1:0] data_o,
   output logic                  parity_err_o,
   output logic                  frame_err_o,
   output logic                  overrun_o,
`ifdef RX_BREAK_DETECT_EN
   output logic                  break_o,
`endif
   output logic                  output_valid_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRKW
   } state_t;

   localparam logic [3:0]           DS_MAX  = 4'(DATA_W_MAX);
   localparam logic [CLK_DIV_W-1:0] CNT_ONE = {{(CLK_DIV_W-1){1'b0}}, 1'b1};

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // acc is the XOR of all data bits and the received parity bit
   function automatic logic parity_bad(input logic [1:0] mode, input logic acc);
      case (mode)
         2'b01:   return ~acc;
         2'b10:   return acc;
         default: return 1'b0;
      endcase
   endfunction

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q, vld_q;
   logic                   sync_prev_q, armed_q;
   logic [CLK_DIV_W-1:0]   div_q, cnt_q;
   logic [3:0]             ds_q, bit_q;
   logic [1:0]             par_q;
   logic                   two_stop_q;
   logic                   s0_q, s1_q, zero_q, ferr_q, par_acc_q, brk_q;
   logic [DATA_W_MAX-1:0]  sh_q, data_q;
   logic                   perr_q, fe_q, ovr_q, valid_q, brk_out_q;

   logic                   sync_s, vote_s, in_frame_s, dec_s, edge_s, par_en_s;
   logic                   last_stop_s, load_s, brk_s, ferr_s, arm_clr_s;
   logic [CLK_DIV_W-1:0]   half_s;
   logic [3:0]             ds_clamp_s;

   // Sample timing, majority vote, start-edge detection and load decode
   always_comb begin
      sync_s      = sync_q[SYNC_STAGES-1];
      half_s      = (div_q >> 1) + {{(CLK_DIV_W-1){1'b0}}, div_q[0]};
      vote_s      = maj3(s0_q, s1_q, sync_s);
      in_frame_s  = (state_q != S_IDLE) && (state_q != S_BRKW);
      dec_s       = in_frame_s && (cnt_q == half_s + CNT_ONE);
      edge_s      = (state_q == S_IDLE) && armed_q && sync_prev_q && !sync_s;
      par_en_s    = (par_q == 2'b01) || (par_q == 2'b10);
      last_stop_s = (state_q == S_STOP2) || ((state_q == S_STOP1) && !two_stop_q);
      load_s      = dec_s && last_stop_s;
      ferr_s      = ferr_q | ~vote_s;
      if (state_q == S_STOP1) begin
         brk_s = zero_q & ~vote_s;
      end else begin
         brk_s = brk_q;
      end
      if (cr_ds_i < 4'd5) begin
         ds_clamp_s = 4'd5;
      end else if (cr_ds_i > DS_MAX) begin
         ds_clamp_s = DS_MAX;
      end else begin
         ds_clamp_s = cr_ds_i;
      end
`ifdef RX_BREAK_DETECT_EN
      arm_clr_s = 1'b0;
`else
      arm_clr_s = load_s & brk_s;
`endif
   end

   // Input synchroniser, line history and arm flag (only real line samples may arm)
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_q      <= {SYNC_STAGES{1'b1}};
         vld_q       <= {SYNC_STAGES{1'b0}};
         sync_prev_q <= 1'b1;
         armed_q     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
         vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         sync_prev_q <= sync_s;
         if (arm_clr_s) begin
            armed_q <= 1'b0;
         end else if (sync_s && vld_q[SYNC_STAGES-1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   // Frame FSM, bit timing, data assembly and the output word register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         div_q      <= {CLK_DIV_W{1'b0}};
         cnt_q      <= {CLK_DIV_W{1'b0}};
         ds_q       <= 4'd5;
         bit_q      <= 4'd0;
         par_q      <= 2'b00;
         two_stop_q <= 1'b0;
         s0_q       <= 1'b1;
         s1_q       <= 1'b1;
         zero_q     <= 1'b0;
         ferr_q     <= 1'b0;
         par_acc_q  <= 1'b0;
         brk_q      <= 1'b0;
         sh_q       <= {DATA_W_MAX{1'b0}};
         data_q     <= {DATA_W_MAX{1'b0}};
         perr_q     <= 1'b0;
         fe_q       <= 1'b0;
         ovr_q      <= 1'b0;
         valid_q    <= 1'b0;
         brk_out_q  <= 1'b0;
      end else begin
         if (cnt_q == div_q) begin
            cnt_q <= {CLK_DIV_W{1'b0}};
         end else begin
            cnt_q <= cnt_q + CNT_ONE;
         end
         if (cnt_q == half_s - CNT_ONE) begin
            s0_q <= sync_s;
         end
         if (cnt_q == half_s) begin
            s1_q <= sync_s;
         end

         case (state_q)
            S_IDLE: begin
               if (edge_s) begin
                  state_q    <= S_START;
                  div_q      <= cr_clk_div_i;
                  ds_q       <= ds_clamp_s;
                  par_q      <= cr_p_i;
                  two_stop_q <= cr_s_i;
                  cnt_q      <= CNT_ONE;
                  zero_q     <= 1'b1;
                  ferr_q     <= 1'b0;
                  par_acc_q  <= 1'b0;
                  brk_q      <= 1'b0;
                  sh_q       <= {DATA_W_MAX{1'b0}};
               end
            end
            S_START: begin
               if (dec_s) begin
                  bit_q   <= 4'd0;
                  state_q <= vote_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (dec_s) begin
                  for (int i = 0; i < DATA_W_MAX; i++) begin
                     if (bit_q == 4'(i)) sh_q[i] <= vote_s;
                  end
                  par_acc_q <= par_acc_q ^ vote_s;
                  zero_q    <= zero_q & ~vote_s;
                  bit_q     <= bit_q + 4'd1;
                  if (bit_q == ds_q - 4'd1) begin
                     state_q <= par_en_s ? S_PARITY : S_STOP1;
                  end
               end
            end
            S_PARITY: begin
               if (dec_s) begin
                  par_acc_q <= par_acc_q ^ vote_s;
                  zero_q    <= zero_q & ~vote_s;
                  state_q   <= S_STOP1;
               end
            end
            S_STOP1: begin
               if (dec_s) begin
                  ferr_q <= ~vote_s;
                  brk_q  <= zero_q & ~vote_s;
                  if (two_stop_q) begin
                     state_q <= S_STOP2;
                  end
               end
            end
            S_STOP2: begin
               // leaving handled by the load path below
            end
            S_BRKW: begin
               if (sync_s) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (load_s) begin
`ifdef RX_BREAK_DETECT_EN
            state_q   <= brk_s ? S_BRKW : S_IDLE;
            fe_q      <= ferr_s & ~brk_s;
            brk_out_q <= brk_s;
`else
            state_q   <= S_IDLE;
            fe_q      <= ferr_s;
            brk_out_q <= 1'b0;
`endif
            data_q    <= sh_q;
            perr_q    <= parity_bad(par_q, par_acc_q);
            ovr_q     <= valid_q & ~output_ready_i;
            valid_q   <= 1'b1;
         end else if (valid_q && output_ready_i) begin
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            brk_out_q <= 1'b0;
         end
      end
   end

   assign data_o         = data_q;
   assign parity_err_o   = perr_q;
   assign frame_err_o    = fe_q;
   assign overrun_o      = ovr_q;
   assign output_valid_o = valid_q;
`ifdef RX_BREAK_DETECT_EN
   assign break_o        = brk_out_q;
`else
   logic unused_brk_s;
   assign unused_brk_s   = brk_out_q;
`endif

endmodule
